// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 key tracking path.
//   - prefix_state_e : E0/F0 prefix decoder states
//   - SC_*           : scan-code constants for prefixes and modifier keys
//   - is_discard()   : keyboard status bytes that carry no key information
//   - ASCII_CASE_DELTA : offset from lowercase to uppercase ASCII letters
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } prefix_state_e;

    localparam logic [7:0] SC_E0      = 8'hE0;
    localparam logic [7:0] SC_F0      = 8'hF0;
    localparam logic [7:0] SC_LSHIFT  = 8'h12;
    localparam logic [7:0] SC_RSHIFT  = 8'h59;
    localparam logic [7:0] SC_CAPS    = 8'h58;

    // Status bytes the keyboard sends outside of key traffic
    localparam logic [7:0] SC_BAT_OK  = 8'hAA;
    localparam logic [7:0] SC_ACK     = 8'hFA;
    localparam logic [7:0] SC_ECHO    = 8'hEE;
    localparam logic [7:0] SC_ERR     = 8'h00;

    localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;

    function automatic logic is_discard(input logic [7:0] code);
        return (code == SC_BAT_OK) || (code == SC_ACK) ||
               (code == SC_ECHO)   || (code == SC_ERR);
    endfunction

endpackage

// File: rtl/ps2_scan_ascii.sv
// ps2_scan_ascii: combinational set-2 scan code to ASCII map.
//   scan  in  8  make code (no prefix)
//   upper in  1  select uppercase for letters
//   ascii out 8  '0'..'9', 'a'..'z' / 'A'..'Z', else 0x00
module ps2_scan_ascii
    import ps2_pkg::*;
(
    input  logic [7:0] scan,
    input  logic       upper,
    output logic [7:0] ascii
);

    logic [7:0] letter;

    always_comb begin
        letter = 8'h00;
        ascii  = 8'h00;
        case (scan)
            8'h45: ascii = "0";
            8'h16: ascii = "1";
            8'h1E: ascii = "2";
            8'h26: ascii = "3";
            8'h25: ascii = "4";
            8'h2E: ascii = "5";
            8'h36: ascii = "6";
            8'h3D: ascii = "7";
            8'h3E: ascii = "8";
            8'h46: ascii = "9";
            8'h1C: letter = "a";
            8'h32: letter = "b";
            8'h21: letter = "c";
            8'h23: letter = "d";
            8'h24: letter = "e";
            8'h2B: letter = "f";
            8'h34: letter = "g";
            8'h33: letter = "h";
            8'h43: letter = "i";
            8'h3B: letter = "j";
            8'h42: letter = "k";
            8'h4B: letter = "l";
            8'h3A: letter = "m";
            8'h31: letter = "n";
            8'h44: letter = "o";
            8'h4D: letter = "p";
            8'h15: letter = "q";
            8'h2D: letter = "r";
            8'h1B: letter = "s";
            8'h2C: letter = "t";
            8'h3C: letter = "u";
            8'h2A: letter = "v";
            8'h1D: letter = "w";
            8'h22: letter = "x";
            8'h35: letter = "y";
            8'h1A: letter = "z";
            default: ;
        endcase
        if (letter != 8'h00) begin
            ascii = upper ? (letter - ASCII_CASE_DELTA) : letter;
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes PS/2 set-2 scan bytes into key state and make-events.
//   clk, resetn            clock, synchronous active-low reset
//   byte_valid/data/ready  scan byte handshake from the receiver
//   key_held/scan/ext      currently held (or last) non-modifier key
//   key_ascii              ASCII of key_scan under current shift/caps
//   shift, caps            modifier state
//   press_cnt              wrapping count of make-events
//   ev_valid/scan/ascii    one-entry make-event register, ev_ready consumes it
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             key_held,
    output logic [7:0]       key_scan,
    output logic             key_ext,
    output logic [7:0]       key_ascii,
    output logic             shift,
    output logic             caps,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ev_valid,
    output logic [7:0]       ev_scan,
    output logic [7:0]       ev_ascii,
    input  logic             ev_ready
);

    prefix_state_e    state_q, state_d;
    logic             rdy_en_q;
    logic             lshift_q, rshift_q, caps_q, caps_held_q;
    logic             key_held_q, key_ext_q;
    logic [7:0]       key_scan_q;
    logic [CNT_W-1:0] press_cnt_q;
    logic             ev_valid_q;
    logic [7:0]       ev_scan_q, ev_ascii_q;

    logic             accept;
    logic             do_make, do_break, cur_ext;
    logic             is_lshift, is_rshift, is_caps, matches_key;
    logic             upper;
    logic [7:0]       key_map_ascii, new_map_ascii;

    // A blocked event stalls the byte stream so no make can be lost
    assign byte_ready = resetn & rdy_en_q & ~(ev_valid_q & ~ev_ready);
    assign accept     = byte_valid & byte_ready;
    assign upper      = (lshift_q | rshift_q) ^ caps_q;

    always_comb begin
        state_d  = state_q;
        do_make  = 1'b0;
        do_break = 1'b0;
        cur_ext  = 1'b0;
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (byte_data == SC_E0) begin
                        state_d = StExt;
                    end else if (byte_data == SC_F0) begin
                        state_d = StBrk;
                    end else if (!is_discard(byte_data)) begin
                        do_make = 1'b1;
                    end
                end
                StExt: begin
                    if (byte_data == SC_F0) begin
                        state_d = StExtBrk;
                    end else if (byte_data != SC_E0) begin
                        do_make = 1'b1;
                        cur_ext = 1'b1;
                        state_d = StIdle;
                    end
                end
                StBrk: begin
                    if (byte_data == SC_E0) begin
                        state_d = StExtBrk;
                    end else if (byte_data != SC_F0) begin
                        do_break = 1'b1;
                        state_d  = StIdle;
                    end
                end
                StExtBrk: begin
                    if (byte_data != SC_E0 && byte_data != SC_F0) begin
                        do_break = 1'b1;
                        cur_ext  = 1'b1;
                        state_d  = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Extended 0x12/0x59 are not shift keys (fake-shift sequences)
    assign is_lshift   = !cur_ext && (byte_data == SC_LSHIFT);
    assign is_rshift   = !cur_ext && (byte_data == SC_RSHIFT);
    assign is_caps     = (byte_data == SC_CAPS);
    assign matches_key = (byte_data == key_scan_q) && (cur_ext == key_ext_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            rdy_en_q    <= 1'b0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            key_held_q  <= 1'b0;
            key_ext_q   <= 1'b0;
            key_scan_q  <= 8'h00;
            press_cnt_q <= '0;
            ev_valid_q  <= 1'b0;
            ev_scan_q   <= 8'h00;
            ev_ascii_q  <= 8'h00;
        end else begin
            rdy_en_q <= 1'b1;
            state_q  <= state_d;
            if (ev_valid_q && ev_ready) begin
                ev_valid_q <= 1'b0;
            end
            if (do_make) begin
                if (is_lshift) begin
                    lshift_q <= 1'b1;
                end else if (is_rshift) begin
                    rshift_q <= 1'b1;
                end else if (is_caps) begin
                    // Typematic repeat of Caps must not re-toggle
                    if (!caps_held_q) begin
                        caps_q <= ~caps_q;
                    end
                    caps_held_q <= 1'b1;
                end else if (!(key_held_q && matches_key)) begin
                    key_scan_q  <= byte_data;
                    key_ext_q   <= cur_ext;
                    key_held_q  <= 1'b1;
                    press_cnt_q <= press_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    // Overrides a same-cycle consume so ev_valid stays high
                    ev_valid_q  <= 1'b1;
                    ev_scan_q   <= byte_data;
                    ev_ascii_q  <= cur_ext ? 8'h00 : new_map_ascii;
                end
            end
            if (do_break) begin
                if (is_lshift) begin
                    lshift_q <= 1'b0;
                end else if (is_rshift) begin
                    rshift_q <= 1'b0;
                end else if (is_caps) begin
                    caps_held_q <= 1'b0;
                end else if (matches_key) begin
                    key_held_q <= 1'b0;
                end
            end
        end
    end

    ps2_scan_ascii u_key_map (
        .scan  (key_scan_q),
        .upper (upper),
        .ascii (key_map_ascii)
    );

    ps2_scan_ascii u_new_map (
        .scan  (byte_data),
        .upper (upper),
        .ascii (new_map_ascii)
    );

    assign key_held  = key_held_q;
    assign key_scan  = key_scan_q;
    assign key_ext   = key_ext_q;
    assign key_ascii = key_ext_q ? 8'h00 : key_map_ascii;
    assign shift     = lshift_q | rshift_q;
    assign caps      = caps_q;
    assign press_cnt = press_cnt_q;
    assign ev_valid  = ev_valid_q;
    assign ev_scan   = ev_scan_q;
    assign ev_ascii  = ev_ascii_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;

    localparam int unsigned CNT_W = 8;

    localparam logic [7:0] LETTER_CODES [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
        8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };
    localparam logic [7:0] DIGIT_CODES [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };
    localparam logic [7:0] POOL [20] = '{
        8'h1C, 8'h32, 8'h16, 8'h45, 8'h1A, 8'h12, 8'h59, 8'h58, 8'hE0, 8'hF0,
        8'hF0, 8'hE0, 8'h75, 8'h6B, 8'hAA, 8'h00, 8'hFA, 8'h1C, 8'h12, 8'hF0
    };

    logic             clk = 1'b0;
    logic             resetn;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             key_held;
    logic [7:0]       key_scan;
    logic             key_ext;
    logic [7:0]       key_ascii;
    logic             shift;
    logic             caps;
    logic [CNT_W-1:0] press_cnt;
    logic             ev_valid;
    logic [7:0]       ev_scan;
    logic [7:0]       ev_ascii;
    logic             ev_ready;

    int checks = 0;
    int failures = 0;

    // Behavioural model: prefix flags, modifier/key state, last event
    bit         m_ext_pfx, m_brk_pfx;
    bit         m_lshift, m_rshift, m_caps, m_caps_held;
    bit         m_held, m_kext;
    logic [7:0] m_scan;
    int         m_cnt;
    bit         m_ev_new;
    logic [7:0] m_ev_scan, m_ev_ascii;

    always #5 clk = ~clk;

    ps2_key_tracker #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .key_held   (key_held),
        .key_scan   (key_scan),
        .key_ext    (key_ext),
        .key_ascii  (key_ascii),
        .shift      (shift),
        .caps       (caps),
        .press_cnt  (press_cnt),
        .ev_valid   (ev_valid),
        .ev_scan    (ev_scan),
        .ev_ascii   (ev_ascii),
        .ev_ready   (ev_ready)
    );

    function automatic logic [7:0] ascii_of(input logic [7:0] code, input bit upper);
        for (int i = 0; i < 26; i++)
            if (LETTER_CODES[i] == code) return upper ? 8'(8'h41 + i) : 8'(8'h61 + i);
        for (int i = 0; i < 10; i++)
            if (DIGIT_CODES[i] == code) return 8'(8'h30 + i);
        return 8'h00;
    endfunction

    function automatic logic [7:0] model_key_ascii();
        return m_kext ? 8'h00 : ascii_of(m_scan, (m_lshift | m_rshift) ^ m_caps);
    endfunction

    task automatic model_reset();
        m_ext_pfx = 0; m_brk_pfx = 0; m_lshift = 0; m_rshift = 0; m_caps = 0;
        m_caps_held = 0; m_held = 0; m_kext = 0; m_scan = 8'h00; m_cnt = 0; m_ev_new = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit is_shift_key;
        m_ev_new = 0;
        if (b == 8'hE0) begin
            m_ext_pfx = 1;
        end else if (b == 8'hF0) begin
            m_brk_pfx = 1;
        end else if (!m_ext_pfx && !m_brk_pfx &&
                     (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'h00)) begin
            // status byte, ignored
        end else begin
            is_shift_key = !m_ext_pfx && (b == 8'h12 || b == 8'h59);
            if (m_brk_pfx) begin
                if (is_shift_key) begin
                    if (b == 8'h12) m_lshift = 0; else m_rshift = 0;
                end else if (b == 8'h58) begin
                    m_caps_held = 0;
                end else if (b == m_scan && m_ext_pfx == m_kext) begin
                    m_held = 0;
                end
            end else begin
                if (is_shift_key) begin
                    if (b == 8'h12) m_lshift = 1; else m_rshift = 1;
                end else if (b == 8'h58) begin
                    if (!m_caps_held) m_caps = !m_caps;
                    m_caps_held = 1;
                end else if (!(m_held && b == m_scan && m_ext_pfx == m_kext)) begin
                    m_ev_ascii = m_ext_pfx ? 8'h00 : ascii_of(b, (m_lshift | m_rshift) ^ m_caps);
                    m_scan = b; m_kext = m_ext_pfx; m_held = 1;
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                    m_ev_new = 1; m_ev_scan = b;
                end
            end
            m_ext_pfx = 0; m_brk_pfx = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        model_reset();
    endtask

    // Offers one byte, waits (bounded) for acceptance, then updates the model
    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data = b;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout byte=%02h got byte_ready=%0b exp=1", b, byte_ready);
            byte_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic test_reset();
        resetn = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; ev_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (byte_ready !== 1'b0) begin failures++;
            $display("FAIL reset_byte_ready got=%0b exp=0", byte_ready); end
        checks++; if ({key_held, key_ext, shift, caps, ev_valid} !== 5'b0) begin failures++;
            $display("FAIL reset_flags got=%05b exp=00000", {key_held, key_ext, shift, caps, ev_valid}); end
        checks++; if (press_cnt !== '0 || key_scan !== 8'h00) begin failures++;
            $display("FAIL reset_regs got cnt=%0d scan=%02h exp=0/00", press_cnt, key_scan); end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (byte_ready !== 1'b1) begin failures++;
            $display("FAIL reset_release_ready got=%0b exp=1", byte_ready); end
        model_reset();
    endtask

    task automatic test_basic_press();
        do_reset();
        send(8'h1C);
        checks++; if (ev_valid !== 1'b1 || ev_scan !== 8'h1C || ev_ascii !== 8'h61) begin failures++;
            $display("FAIL basic_event got v=%0b scan=%02h ascii=%02h exp=1/1c/61", ev_valid, ev_scan, ev_ascii); end
        checks++; if (press_cnt !== 8'd1 || key_held !== 1'b1) begin failures++;
            $display("FAIL basic_state got cnt=%0d held=%0b exp=1/1", press_cnt, key_held); end
        send(8'hF0);
        send(8'h1C);
        checks++; if (key_held !== 1'b0 || key_scan !== 8'h1C || ev_valid !== 1'b0) begin failures++;
            $display("FAIL basic_release got held=%0b scan=%02h ev=%0b exp=0/1c/0", key_held, key_scan, ev_valid); end
    endtask

    task automatic test_shift_typematic();
        do_reset();
        send(8'h12);
        checks++; if (shift !== 1'b1 || ev_valid !== 1'b0 || press_cnt !== 8'd0) begin failures++;
            $display("FAIL shift_make got shift=%0b ev=%0b cnt=%0d exp=1/0/0", shift, ev_valid, press_cnt); end
        send(8'h1C);
        checks++; if (ev_valid !== 1'b1 || ev_ascii !== 8'h41) begin failures++;
            $display("FAIL shift_event got v=%0b ascii=%02h exp=1/41", ev_valid, ev_ascii); end
        for (int i = 0; i < 2; i++) begin
            send(8'h1C);
            checks++; if (ev_valid !== 1'b0) begin failures++;
                $display("FAIL typematic_repeat_%0d got ev_valid=%0b exp=0", i, ev_valid); end
        end
        send(8'hF0); send(8'h1C);
        checks++; if (key_held !== 1'b0 || key_ascii !== 8'h41) begin failures++;
            $display("FAIL shift_release_key got held=%0b ascii=%02h exp=0/41", key_held, key_ascii); end
        send(8'hF0); send(8'h12);
        checks++; if (shift !== 1'b0 || press_cnt !== 8'd1 || key_ascii !== 8'h61) begin failures++;
            $display("FAIL shift_release got shift=%0b cnt=%0d ascii=%02h exp=0/1/61", shift, press_cnt, key_ascii); end
    endtask

    task automatic test_caps();
        do_reset();
        send(8'h58); send(8'h58);
        checks++; if (caps !== 1'b1 || ev_valid !== 1'b0) begin failures++;
            $display("FAIL caps_repeat got caps=%0b ev=%0b exp=1/0", caps, ev_valid); end
        send(8'hF0); send(8'h58); send(8'h32);
        checks++; if (caps !== 1'b1 || ev_valid !== 1'b1 || ev_ascii !== 8'h42) begin failures++;
            $display("FAIL caps_event got caps=%0b v=%0b ascii=%02h exp=1/1/42", caps, ev_valid, ev_ascii); end
        send(8'h58);
        checks++; if (caps !== 1'b0 || key_ascii !== 8'h62) begin failures++;
            $display("FAIL caps_toggle_off got caps=%0b ascii=%02h exp=0/62", caps, key_ascii); end
    endtask

    task automatic test_extended();
        do_reset();
        send(8'hE0); send(8'h75);
        checks++; if (ev_valid !== 1'b1 || ev_scan !== 8'h75 || ev_ascii !== 8'h00 || key_ext !== 1'b1) begin
            failures++;
            $display("FAIL ext_event got v=%0b scan=%02h ascii=%02h ext=%0b exp=1/75/00/1",
                     ev_valid, ev_scan, ev_ascii, key_ext); end
        send(8'hF0); send(8'h75);
        checks++; if (key_held !== 1'b1) begin failures++;
            $display("FAIL ext_plain_break got held=%0b exp=1", key_held); end
        send(8'hE0); send(8'hF0); send(8'h75);
        checks++; if (key_held !== 1'b0 || key_scan !== 8'h75 || key_ascii !== 8'h00) begin failures++;
            $display("FAIL ext_break got held=%0b scan=%02h ascii=%02h exp=0/75/00", key_held, key_scan, key_ascii); end
    endtask

    task automatic test_backpressure();
        do_reset();
        ev_ready = 1'b0;
        send(8'h1C);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data = 8'h16;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (byte_ready !== 1'b0 || ev_valid !== 1'b1 || ev_scan !== 8'h1C) begin failures++;
                $display("FAIL bp_stall_%0d got rdy=%0b v=%0b scan=%02h exp=0/1/1c", i, byte_ready, ev_valid, ev_scan); end
            @(negedge clk);
        end
        ev_ready = 1'b1;
        #1;
        checks++; if (byte_ready !== 1'b1) begin failures++;
            $display("FAIL bp_ready_release got=%0b exp=1", byte_ready); end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        ev_ready = 1'b0;
        model_byte(8'h16);
        checks++; if (ev_valid !== 1'b1 || ev_scan !== 8'h16 || ev_ascii !== 8'h31 || press_cnt !== 8'd2) begin
            failures++;
            $display("FAIL bp_overwrite got v=%0b scan=%02h ascii=%02h cnt=%0d exp=1/16/31/2",
                     ev_valid, ev_scan, ev_ascii, press_cnt); end
        ev_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (ev_valid !== 1'b0) begin failures++;
            $display("FAIL bp_consume got ev_valid=%0b exp=0", ev_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] code;
            code = (i % 2 == 0) ? 8'h1C : 8'h32;
            send(code); send(8'hF0); send(code);
            if (i == 254) begin
                checks++; if (press_cnt !== 8'd255) begin failures++;
                    $display("FAIL wrap_255 got=%0d exp=255", press_cnt); end
            end
        end
        checks++; if (press_cnt !== 8'd0 || press_cnt !== CNT_W'(m_cnt)) begin failures++;
            $display("FAIL wrap_0 got=%0d exp=0", press_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ev_ready = 1'b0;
        send(8'h1C);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (ev_valid !== 1'b0 || byte_ready !== 1'b0) begin failures++;
            $display("FAIL reset_drop_event got v=%0b rdy=%0b exp=0/0", ev_valid, byte_ready); end
        @(negedge clk);
        resetn = 1'b1;
        ev_ready = 1'b1;
        @(posedge clk);
        model_reset();
        send(8'hE0);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        model_reset();
        send(8'h1C);
        checks++; if (ev_valid !== 1'b1 || ev_scan !== 8'h1C || key_ext !== 1'b0 || ev_ascii !== 8'h61) begin
            failures++;
            $display("FAIL reset_mid_ext got v=%0b scan=%02h ext=%0b ascii=%02h exp=1/1c/0/61",
                     ev_valid, ev_scan, key_ext, ev_ascii); end
    endtask

    task automatic test_random();
        do_reset();
        ev_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : POOL[$urandom_range(0, 19)];
            send(b);
            checks++; if (key_held !== m_held || key_scan !== m_scan || key_ext !== m_kext) begin failures++;
                $display("FAIL rand_key[%0d] byte=%02h got %0b/%02h/%0b exp %0b/%02h/%0b",
                         i, b, key_held, key_scan, key_ext, m_held, m_scan, m_kext); end
            checks++; if (shift !== (m_lshift | m_rshift) || caps !== m_caps) begin failures++;
                $display("FAIL rand_mod[%0d] got shift=%0b caps=%0b exp %0b/%0b",
                         i, shift, caps, m_lshift | m_rshift, m_caps); end
            checks++; if (key_ascii !== model_key_ascii() || press_cnt !== CNT_W'(m_cnt)) begin failures++;
                $display("FAIL rand_ascii_cnt[%0d] got %02h/%0d exp %02h/%0d",
                         i, key_ascii, press_cnt, model_key_ascii(), m_cnt); end
            checks++; if (ev_valid !== m_ev_new) begin failures++;
                $display("FAIL rand_ev_valid[%0d] got=%0b exp=%0b", i, ev_valid, m_ev_new); end
            if (m_ev_new) begin
                checks++; if (ev_scan !== m_ev_scan || ev_ascii !== m_ev_ascii) begin failures++;
                    $display("FAIL rand_ev[%0d] got %02h/%02h exp %02h/%02h",
                             i, ev_scan, ev_ascii, m_ev_scan, m_ev_ascii); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_press();
        test_shift_typematic();
        test_caps();
        test_extended();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Protocol stage between the PS/2 byte receiver and the seven-segment/ASCII display logic. Consumes raw scan-code bytes over a valid/ready handshake. Decodes E0 (extended) and F0 (break) prefixes and tracks the currently held key, Shift and Caps Lock. Emits one make-event per genuine new key press, carrying scan code and ASCII, and keeps a wrapping press counter.

## Interface
Parameters:
- CNT_W, 8, width of press counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  synchronous active-low reset
- byte_valid  in  1  receiver has a scan byte
- byte_data  in  8  scan byte
- byte_ready  out  1  byte accepted on cycles where byte_valid && byte_ready
- key_held  out  1  a non-modifier key is currently pressed
- key_scan  out  8  scan code of held/last key
- key_ext  out  1  held/last key was E0-prefixed
- key_ascii  out  8  ASCII of key_scan under current Shift/Caps; 0x00 if unmapped or extended
- shift  out  1  either Shift key held
- caps  out  1  Caps Lock toggle state
- press_cnt  out  CNT_W  count of make-events, wraps
- ev_valid  out  1  make-event pending
- ev_scan  out  8  event scan code
- ev_ascii  out  8  event ASCII, captured at event time
- ev_ready  in  1  consumer takes event when ev_valid && ev_ready

## Operation
- Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
  - IDLE: E0→EXT, F0→BRK, else make(code, ext=0).
  - EXT: F0→EXT_BRK, E0 stays, else make(code, ext=1)→IDLE.
  - BRK: E0→EXT_BRK, F0 stays, else break(code, ext=0)→IDLE.
  - EXT_BRK: E0/F0 stay, else break(code, ext=1)→IDLE.
- Bytes 0xAA, 0xFA, 0xEE and 0x00 in IDLE are discarded with no state change.
- make, non-ext 0x12/0x59: set corresponding shift bit. No event, no count.
- make 0x58: toggle caps only if Caps is not already held (typematic repeat does not re-toggle). No event.
- make, other code:
  - If key_held, the code equals key_scan and ext equals key_ext, it is a typematic repeat and is ignored.
  - Otherwise: key_scan/key_ext ← code/ext, key_held ← 1, press_cnt +1 (2^CNT_W−1 → 0), event raised.
- break:
  - Of a Shift key: clears that shift bit.
  - Of 0x58: clears the Caps-held flag.
  - Matching key_scan and key_ext: key_held ← 0; key_scan is kept.
  - Any other break is ignored.
- ASCII map:
  - Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 → "0".."9".
  - Standard set-2 letter codes → "a".."z", uppercased (−0x20) when shift XOR caps.
  - Everything else → 0x00.
- Event register is one entry.
  - byte_ready = ~(ev_valid & ~ev_ready), so no byte is accepted while an event is blocked.
  - Simultaneous event consume and new event in the same cycle: the new event overwrites, and ev_valid stays 1.

## Timing
- Reset values: byte_ready 0 during reset and 1 the cycle after. All other outputs, the FSM and the Caps-held flag reset to 0 / IDLE.
- One byte is processed per accepted cycle. State and key outputs update on the edge that accepts the byte.
- ev_valid rises the cycle after the accepting edge. It holds with stable ev_scan/ev_ascii until ev_ready.
- key_ascii is combinational from registered key_scan, shift and caps, so it tracks Shift changes immediately.
- Reset mid-sequence (e.g. after E0) returns to IDLE. A pending event is dropped.

## Structure
- Package ps2_pkg holds:
  - FSM state enum.
  - Constants SC_E0=0xE0, SC_F0=0xF0, SC_LSHIFT=0x12, SC_RSHIFT=0x59, SC_CAPS=0x58.
  - Discard codes.
- Sub-module ps2_scan_ascii is a purely combinational scan-code (plus upper flag) to ASCII map. It is shared with the display path.

## Test plan
- 0x1C, 0xF0, 0x1C → event scan 0x1C ascii 0x61; press_cnt 1; key_held 1 then 0.
- 0x12, 0x1C, 0x1C, 0x1C, 0xF0, 0x1C, 0xF0, 0x12 → single event ascii 0x41; press_cnt 1; shift returns to 0.
- 0x58, 0x58, 0xF0, 0x58, then 0x32 → caps 1 (repeat did not toggle); event ascii 0x42.
- E0 75, E0 F0 75 → event scan 0x75, key_ext 1, ascii 0x00; key_held returns to 0. A plain F0 75 in the middle does not release it.
- Hold ev_ready 0 after one event, then offer 0x16 → byte_ready 0 until ev_ready is pulsed. Then 0x16 is accepted and the event has ascii 0x31.
- 256 distinct press/release pairs → press_cnt wraps to 0. Assert resetn low right after an E0 → next 0x1C produces a non-ext event.
